hand_bank: RTL and testbench
============================

Name: hand_bank

Overview:
Parametrised successor to the fixed two-hand, three-card baccarat datapath registers. It holds HANDS independent hands of up to MAX_CARDS cards each. Cards are appended in order under a single load strobe, and each hand's score is maintained incrementally, modulo 10. Every stored card is presented on its own active-low 7-segment code, and the block sits between the dealcard source and the game FSM.

Parameters:
HANDS, 2, number of hands (≥2); hand 0 = player, hand 1 = dealer by convention
MAX_CARDS, 3, card slots per hand (≥2)
HW, $clog2(HANDS), hand-select width (localparam)
CW, $clog2(MAX_CARDS+1), per-hand count width (localparam)

Ports:
slow_clock  in  1  single clock; all state changes on posedge
resetb  in  1  synchronous active-low reset
new_card  in  4  card code: 1=A, 2..10, 11=J, 12=Q, 13=K; 0, 14 and 15 are invalid
load_valid  in  1  append new_card to hand load_hand this edge
load_hand  in  HW  target hand of load
clear_valid  in  1  empty hand clear_hand this edge
clear_hand  in  HW  target hand of clear
cards_out  out  HANDS*MAX_CARDS*4  slot s of hand h at bits [(h*MAX_CARDS+s)*4 +: 4]
hex_out  out  HANDS*MAX_CARDS*7  7-seg code of the matching slot, same indexing ×7
score_out  out  HANDS*4  score of hand h at [h*4 +: 4], range 0..9
count_out  out  HANDS*CW  cards held per hand
full_out  out  HANDS  hand h holds MAX_CARDS cards
last_card_out  out  HANDS*4  most recently loaded card per hand, 0 if the hand is empty
err  out  1  sticky: a rejected load occurred

Behaviour:
- Reset, sampled at posedge with resetb=0, sets:
  - every card, score, count, last_card and err to 0
  - every hex_out field to 7'b1111111
  - reset wins over all other inputs
- Load with load_valid=1, valid card, hand h not full, at edge N:
  - slot count[h] ← new_card
  - count[h] ← count[h]+1
  - last_card[h] ← new_card
  - score[h] ← (score[h] + val(new_card)) mod 10
  - All of these are visible after edge N. Latency is one edge; there are no wait states.
- Card value: val = code for 1..9, and 0 for 10/J/Q/K.
  - Computed as a 5-bit sum; 10 is subtracted if the sum is ≥10 (the sum never exceeds 18).
- Rejected load leaves all hand state unchanged and sets err=1. A load is rejected when any of these holds:
  - hand h is full
  - new_card is 0, 14 or 15
  - load_hand ≥ HANDS
- err clears only on reset.
- Clear with clear_valid=1, hand h, at edge N:
  - slots, count, score and last_card of hand h go to 0 after edge N
  - hex of every slot in hand h goes to blank
  - err is unaffected
- Simultaneous clear and load:
  - Same hand: clear wins, the load is discarded, err is not set.
  - Different hands: both take effect at the same edge.
- Hands other than the one addressed hold their values.
- hex_out is combinational from the stored card, active-low, bit order gfedcba (bit 6 = g):
  - 0 → 1111111
  - A → 0001000
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 10 → 1000000
  - J → 1100001
  - Q → 0011000
  - K → 0001001
  - 14, 15 → 1111111
- full_out[h] = (count[h] == MAX_CARDS), combinational from the registered count.
- No state machine beyond the per-hand count. Each hand's count is a saturating append pointer with three cases: empty (0), partial, and full (MAX_CARDS).

Decomposition:
- Package hand_bank_pkg holds:
  - card_t (logic [3:0])
  - card code constants CARD_NONE, CARD_ACE, CARD_J, CARD_Q, CARD_K
  - SEG_BLANK
  - function card_value(card_t) returning 0..9
- Sub-module card7seg is instantiated HANDS*MAX_CARDS times via generate: pure combinational, card[3:0] → seg7[6:0] per the table above.

Test Plan:
- Reset held 5 edges, then released → all outputs 0, every hex_out field 1111111, err=0.
- Hand 0 ← 3, hand 1 ← J, hand 0 ← 5, hand 1 ← 7, one per edge → score0=8, score1=7, hex slot(0,0)=0110000, slot(0,1)=0010010, slot(1,0)=1100001, slot(1,1)=1111000; last_card0=5.
- Hand 0 ← 9, 8, 7 → scores after each edge 9, 7, 4; full_out[0]=1; a 4th load of K → state unchanged, err=1 on the next edge; err stays 1 after a later valid load to hand 1.
- load_valid with new_card=0, then 14 → no slot written, count unchanged, err=1.
- clear_valid and load_valid both targeting hand 1 (holding 2 cards) at the same edge → count1=0, score1=0, hex blank; the load is lost and err is unchanged. Clear hand 0 while loading A into hand 1 at the same edge → hand 0 empty, hand 1 holds A with score 1.
- Partial hand with resetb=0 for one edge → everything returns to reset values at that edge. Re-run with HANDS=4, MAX_CARDS=5: load hand 3 five times with 6 → scores 6, 2, 8, 4, 0, full_out=4'b1000.

Source files
------------

// File: rtl/hand_bank_pkg.sv
// Shared card types, code constants and helpers for the hand_bank slice.
// The card encoding and 7-segment blank pattern live here so every file agrees on them.
package hand_bank_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_NONE = 4'd0;
  localparam card_t CARD_ACE  = 4'd1;
  localparam card_t CARD_J    = 4'd11;
  localparam card_t CARD_Q    = 4'd12;
  localparam card_t CARD_K    = 4'd13;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic card_is_valid(input card_t c);
    return (c >= CARD_ACE) && (c <= CARD_K);
  endfunction

  // Baccarat value: pips count face value, tens and court cards count zero.
  function automatic logic [3:0] card_value(input card_t c);
    if ((c >= CARD_ACE) && (c <= 4'd9)) return c;
    else return 4'd0;
  endfunction

endpackage

// File: rtl/card7seg.sv
// Active-low gfedcba 7-segment decoder for one stored card.
module card7seg
  import hand_bank_pkg::*;
(
  input  card_t      card,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = SEG_BLANK;
    case (card)
      CARD_NONE: seg7 = SEG_BLANK;
      CARD_ACE:  seg7 = 7'b0001000;
      4'd2:      seg7 = 7'b0100100;
      4'd3:      seg7 = 7'b0110000;
      4'd4:      seg7 = 7'b0011001;
      4'd5:      seg7 = 7'b0010010;
      4'd6:      seg7 = 7'b0000010;
      4'd7:      seg7 = 7'b1111000;
      4'd8:      seg7 = 7'b0000000;
      4'd9:      seg7 = 7'b0010000;
      4'd10:     seg7 = 7'b1000000;
      CARD_J:    seg7 = 7'b1100001;
      CARD_Q:    seg7 = 7'b0011000;
      CARD_K:    seg7 = 7'b0001001;
      default:   seg7 = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hand_bank.sv
// Bank of HANDS card hands with in-order append, incremental mod-10 scores
// and a sticky error flag for rejected loads.
module hand_bank
  import hand_bank_pkg::*;
#(
  parameter  int HANDS     = 2,
  parameter  int MAX_CARDS = 3,
  localparam int HW        = $clog2(HANDS),
  localparam int CW        = $clog2(MAX_CARDS + 1)
) (
  input  logic                         slow_clock,
  input  logic                         resetb,
  input  card_t                        new_card,
  input  logic                         load_valid,
  input  logic [HW-1:0]                load_hand,
  input  logic                         clear_valid,
  input  logic [HW-1:0]                clear_hand,
  output logic [HANDS*MAX_CARDS*4-1:0] cards_out,
  output logic [HANDS*MAX_CARDS*7-1:0] hex_out,
  output logic [HANDS*4-1:0]           score_out,
  output logic [HANDS*CW-1:0]          count_out,
  output logic [HANDS-1:0]             full_out,
  output logic [HANDS*4-1:0]           last_card_out,
  output logic                         err
);

  localparam logic [HW:0]   NUM_HANDS  = (HW + 1)'(HANDS);
  localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_CARDS);

  card_t         cards [HANDS][MAX_CARDS];
  logic [CW-1:0] count [HANDS];
  logic [3:0]    score [HANDS];
  card_t         last_card [HANDS];
  logic [4:0]    score_sum [HANDS];
  logic [3:0]    next_score [HANDS];
  logic [HANDS-1:0] full;

  logic card_ok, hand_ok, target_full, load_hit_clear, load_accept, load_reject;

  // A load that collides with a clear of the same hand is silently dropped,
  // so it neither writes nor counts as a rejection.
  always_comb begin
    card_ok        = card_is_valid(new_card);
    hand_ok        = {1'b0, load_hand} < NUM_HANDS;
    target_full    = 1'b0;
    for (int h = 0; h < HANDS; h++) begin
      if (load_hand == HW'(h)) target_full = full[h];
    end
    load_hit_clear = clear_valid && (clear_hand == load_hand);
    load_accept    = load_valid && !load_hit_clear && card_ok && hand_ok && !target_full;
    load_reject    = load_valid && !load_hit_clear && !(card_ok && hand_ok && !target_full);
  end

  always_comb begin
    for (int h = 0; h < HANDS; h++) begin
      score_sum[h]  = {1'b0, score[h]} + {1'b0, card_value(new_card)};
      next_score[h] = (score_sum[h] >= 5'd10) ? 4'(score_sum[h] - 5'd10) : score_sum[h][3:0];
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      for (int h = 0; h < HANDS; h++) begin
        count[h]     <= '0;
        score[h]     <= '0;
        last_card[h] <= CARD_NONE;
        for (int s = 0; s < MAX_CARDS; s++) cards[h][s] <= CARD_NONE;
      end
      err <= 1'b0;
    end else begin
      for (int h = 0; h < HANDS; h++) begin
        if (clear_valid && (clear_hand == HW'(h))) begin
          count[h]     <= '0;
          score[h]     <= '0;
          last_card[h] <= CARD_NONE;
          for (int s = 0; s < MAX_CARDS; s++) cards[h][s] <= CARD_NONE;
        end else if (load_accept && (load_hand == HW'(h))) begin
          // The count doubles as the append pointer into the slot array.
          for (int s = 0; s < MAX_CARDS; s++) begin
            if (count[h] == CW'(s)) cards[h][s] <= new_card;
          end
          count[h]     <= count[h] + CW'(1);
          score[h]     <= next_score[h];
          last_card[h] <= new_card;
        end
      end
      if (load_reject) err <= 1'b1;
    end
  end

  for (genvar gh = 0; gh < HANDS; gh++) begin : g_hand
    assign full[gh]                     = (count[gh] == FULL_COUNT);
    assign score_out[gh*4 +: 4]         = score[gh];
    assign count_out[gh*CW +: CW]       = count[gh];
    assign last_card_out[gh*4 +: 4]     = last_card[gh];
    for (genvar gs = 0; gs < MAX_CARDS; gs++) begin : g_slot
      assign cards_out[(gh*MAX_CARDS+gs)*4 +: 4] = cards[gh][gs];
      card7seg u_seg (
        .card (cards[gh][gs]),
        .seg7 (hex_out[(gh*MAX_CARDS+gs)*7 +: 7])
      );
    end
  end

  assign full_out = full;

endmodule

// File: tb/tb_hand_bank.sv
// Self-checking bench for hand_bank: a vector table driven through a scoreboard
// queue, then hand-written reset, collision, invalid-card and 4x5 sequences.
module tb_hand_bank;

  logic        slow_clock = 1'b0;
  logic        resetb;
  logic [3:0]  new_card;
  logic        load_valid;
  logic [0:0]  load_hand;
  logic        clear_valid;
  logic [0:0]  clear_hand;
  logic [23:0] cards_out;
  logic [41:0] hex_out;
  logic [7:0]  score_out;
  logic [3:0]  count_out;
  logic [1:0]  full_out;
  logic [7:0]  last_card_out;
  logic        err;

  logic [3:0]   big_new_card;
  logic         big_load_valid;
  logic [1:0]   big_load_hand;
  logic         big_clear_valid;
  logic [1:0]   big_clear_hand;
  logic [79:0]  big_cards_out;
  logic [139:0] big_hex_out;
  logic [15:0]  big_score_out;
  logic [11:0]  big_count_out;
  logic [3:0]   big_full_out;
  logic [15:0]  big_last_card_out;
  logic         big_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       lv;
    logic [0:0] lh;
    logic [3:0] card;
    logic       cv;
    logic [0:0] ch;
    logic [3:0] s0, s1;
    logic [1:0] c0, c1;
    logic [3:0] l0, l1;
    logic       e;
    logic [1:0] f;
  } vec_t;

  vec_t vecs[17];
  vec_t exp_q[$];

  hand_bank u_dut (
    .slow_clock    (slow_clock),
    .resetb        (resetb),
    .new_card      (new_card),
    .load_valid    (load_valid),
    .load_hand     (load_hand),
    .clear_valid   (clear_valid),
    .clear_hand    (clear_hand),
    .cards_out     (cards_out),
    .hex_out       (hex_out),
    .score_out     (score_out),
    .count_out     (count_out),
    .full_out      (full_out),
    .last_card_out (last_card_out),
    .err           (err)
  );

  hand_bank #(.HANDS(4), .MAX_CARDS(5)) u_big (
    .slow_clock    (slow_clock),
    .resetb        (resetb),
    .new_card      (big_new_card),
    .load_valid    (big_load_valid),
    .load_hand     (big_load_hand),
    .clear_valid   (big_clear_valid),
    .clear_hand    (big_clear_hand),
    .cards_out     (big_cards_out),
    .hex_out       (big_hex_out),
    .score_out     (big_score_out),
    .count_out     (big_count_out),
    .full_out      (big_full_out),
    .last_card_out (big_last_card_out),
    .err           (big_err)
  );

  always #5 slow_clock = ~slow_clock;

  function automatic vec_t mk(input logic lv, input logic [0:0] lh, input logic [3:0] card,
                              input logic cv, input logic [0:0] ch,
                              input logic [3:0] s0, input logic [3:0] s1,
                              input logic [1:0] c0, input logic [1:0] c1,
                              input logic [3:0] l0, input logic [3:0] l1,
                              input logic e, input logic [1:0] f);
    vec_t v;
    v.lv = lv; v.lh = lh; v.card = card; v.cv = cv; v.ch = ch;
    v.s0 = s0; v.s1 = s1; v.c0 = c0; v.c1 = c1; v.l0 = l0; v.l1 = l1; v.e = e; v.f = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic idle();
    load_valid = 1'b0; clear_valid = 1'b0; new_card = 4'd0; load_hand = 1'b0; clear_hand = 1'b0;
  endtask

  function automatic logic [6:0] hex_slot(input int h, input int s);
    return hex_out[(h*3+s)*7 +: 7];
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_q.push_back(v);
    load_valid = v.lv; load_hand = v.lh; new_card = v.card;
    clear_valid = v.cv; clear_hand = v.ch;
    step();
    idle();
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " score0"}, score_out[3:0], e.s0);
    check({tag, " score1"}, score_out[7:4], e.s1);
    check({tag, " count0"}, count_out[1:0], e.c0);
    check({tag, " count1"}, count_out[3:2], e.c1);
    check({tag, " last0"},  last_card_out[3:0], e.l0);
    check({tag, " last1"},  last_card_out[7:4], e.l1);
    check({tag, " err"},    err, e.e);
    check({tag, " full"},   full_out, e.f);
  endtask

  initial begin
    resetb = 1'b0;
    idle();
    big_load_valid = 1'b0; big_clear_valid = 1'b0; big_new_card = 4'd0;
    big_load_hand = 2'd0; big_clear_hand = 2'd0;

    // Reset held five edges.
    repeat (5) step();
    resetb = 1'b1;
    check("reset cards", cards_out, 32'd0);
    check("reset score", score_out, 32'd0);
    check("reset count", count_out, 32'd0);
    check("reset last", last_card_out, 32'd0);
    check("reset full", full_out, 32'd0);
    check("reset err", err, 32'd0);
    check("reset hex blank", &hex_out, 32'd1);
    check("big reset hex blank", &big_hex_out, 32'd1);
    check("big reset count", big_count_out, 32'd0);

    //            lv   lh  card cv   ch  s0 s1 c0 c1 l0  l1  e  f
    vecs[0]  = mk(1, 0, 3,  0, 0, 3, 0, 1, 0, 3, 0,  0, 2'b00);
    vecs[1]  = mk(1, 1, 11, 0, 0, 3, 0, 1, 1, 3, 11, 0, 2'b00);
    vecs[2]  = mk(1, 0, 5,  0, 0, 8, 0, 2, 1, 5, 11, 0, 2'b00);
    vecs[3]  = mk(1, 1, 7,  0, 0, 8, 7, 2, 2, 5, 7,  0, 2'b00);
    vecs[4]  = mk(0, 0, 0,  1, 0, 0, 7, 0, 2, 0, 7,  0, 2'b00);
    vecs[5]  = mk(1, 0, 9,  0, 0, 9, 7, 1, 2, 9, 7,  0, 2'b00);
    vecs[6]  = mk(1, 0, 8,  0, 0, 7, 7, 2, 2, 8, 7,  0, 2'b00);
    vecs[7]  = mk(1, 0, 7,  0, 0, 4, 7, 3, 2, 7, 7,  0, 2'b01);
    vecs[8]  = mk(1, 0, 13, 0, 0, 4, 7, 3, 2, 7, 7,  1, 2'b01);
    vecs[9]  = mk(1, 1, 1,  0, 0, 4, 8, 3, 3, 7, 1,  1, 2'b11);
    vecs[10] = mk(0, 0, 0,  1, 1, 4, 0, 3, 0, 7, 0,  1, 2'b01);
    vecs[11] = mk(1, 1, 0,  0, 0, 4, 0, 3, 0, 7, 0,  1, 2'b01);
    vecs[12] = mk(1, 1, 14, 0, 0, 4, 0, 3, 0, 7, 0,  1, 2'b01);
    vecs[13] = mk(1, 1, 2,  0, 0, 4, 2, 3, 1, 7, 2,  1, 2'b01);
    vecs[14] = mk(1, 1, 4,  0, 0, 4, 6, 3, 2, 7, 4,  1, 2'b01);
    vecs[15] = mk(1, 1, 5,  1, 1, 4, 0, 3, 0, 7, 0,  1, 2'b01);
    vecs[16] = mk(1, 1, 1,  1, 0, 0, 1, 0, 1, 0, 1,  1, 2'b00);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
      if (i == 3) begin
        check("hex slot00", hex_slot(0, 0), 7'b0110000);
        check("hex slot01", hex_slot(0, 1), 7'b0010010);
        check("hex slot10", hex_slot(1, 0), 7'b1100001);
        check("hex slot11", hex_slot(1, 1), 7'b1111000);
      end
    end
    check("hand1 slot0 ace", cards_out[15:12], 32'd1);
    check("hand1 hex ace", hex_slot(1, 0), 7'b0001000);
    check("hand0 hex blank after clear", &hex_out[20:0], 32'd1);

    // One-edge reset from a partial hand.
    resetb = 1'b0;
    load_valid = 1'b1; load_hand = 1'b1; new_card = 4'd6;
    step();
    resetb = 1'b1;
    idle();
    check("midreset cards", cards_out, 32'd0);
    check("midreset score", score_out, 32'd0);
    check("midreset count", count_out, 32'd0);
    check("midreset err", err, 32'd0);
    check("midreset hex blank", &hex_out, 32'd1);

    // Same-hand clear and load with err clear beforehand.
    load_valid = 1'b1; load_hand = 1'b1; new_card = 4'd2; step();
    new_card = 4'd3; step();
    check("pre-collide count1", count_out[3:2], 32'd2);
    check("pre-collide score1", score_out[7:4], 32'd5);
    check("hex 2", hex_slot(1, 0), 7'b0100100);
    new_card = 4'd4; clear_valid = 1'b1; clear_hand = 1'b1; step();
    idle();
    check("collide count1", count_out[3:2], 32'd0);
    check("collide score1", score_out[7:4], 32'd0);
    check("collide hex1 blank", &hex_out[41:21], 32'd1);
    check("collide err", err, 32'd0);

    // Invalid card codes.
    load_valid = 1'b1; load_hand = 1'b0; new_card = 4'd0; step();
    check("card0 count0", count_out[1:0], 32'd0);
    check("card0 err", err, 32'd1);
    new_card = 4'd14; step();
    idle();
    check("card14 count0", count_out[1:0], 32'd0);
    check("card14 slot", cards_out[3:0], 32'd0);
    check("card14 err", err, 32'd1);

    // 4-hand, 5-card instance: fill hand 3 with sixes.
    begin
      logic [3:0] big_exp [5];
      big_exp[0] = 4'd6; big_exp[1] = 4'd2; big_exp[2] = 4'd8; big_exp[3] = 4'd4; big_exp[4] = 4'd0;
      for (int i = 0; i < 5; i++) begin
        big_load_valid = 1'b1; big_load_hand = 2'd3; big_new_card = 4'd6;
        step();
        check($sformatf("big score3 #%0d", i), big_score_out[15:12], big_exp[i]);
      end
    end
    big_load_valid = 1'b0;
    check("big count3", big_count_out[11:9], 32'd5);
    check("big full", big_full_out, 32'd8);
    check("big err", big_err, 32'd0);
    check("big hex 6", big_hex_out[(15+4)*7 +: 7], 7'b0000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
